// File: rtl/grid_arbiter.sv
// grid_arbiter: round-robin req/grant owner of the single-port grid memory.
//   Requester 0 = level loader (read/write), 1 = grid renderer (read-only),
//   2 = raytracer (read-only). Ownership is held while the owner keeps req
//   high; a release costs one dead cycle before the next grant.
// Ports:
//   clock, reset          : system clock, synchronous active-high reset
//   req[2:0]              : request/hold line per requester
//   r0_x/r0_y/r0_write/r0_in, r1_x/r1_y, r2_x/r2_y : requester address/data
//   grant[2:0]            : registered one-hot owner
//   rd_valid[2:0]         : grid_out holds data for requester i's previous address
//   grid_x/grid_y/grid_write/grid_in : grid memory pins
//   busy                  : any grant bit set
module grid_arbiter #(
    parameter int X_W = 6,
    parameter int Y_W = 5,
    parameter int D_W = 3
) (
    input  logic           clock,
    input  logic           reset,
    input  logic [2:0]     req,
    input  logic [X_W-1:0] r0_x,
    input  logic [Y_W-1:0] r0_y,
    input  logic           r0_write,
    input  logic [D_W-1:0] r0_in,
    input  logic [X_W-1:0] r1_x,
    input  logic [Y_W-1:0] r1_y,
    input  logic [X_W-1:0] r2_x,
    input  logic [Y_W-1:0] r2_y,
    output logic [2:0]     grant,
    output logic [2:0]     rd_valid,
    output logic [X_W-1:0] grid_x,
    output logic [Y_W-1:0] grid_y,
    output logic           grid_write,
    output logic [D_W-1:0] grid_in,
    output logic           busy
);

    typedef enum logic {IDLE, OWN} state_t;

    state_t     state;
    logic [1:0] last_owner;
    logic [1:0] winner;
    logic       owner_holds;

    // Round-robin search starting just after the previous owner, so the
    // previous owner only wins again when nobody else is asking.
    always_comb begin
        winner = last_owner;
        for (int k = 3; k >= 1; k--) begin
            int c;
            c = (int'(last_owner) + k) % 3;
            if (req[c]) winner = 2'(c);
        end
    end

    assign owner_holds = |(grant & req);

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            grant      <= 3'b000;
            last_owner <= 2'd2;
            rd_valid   <= 3'b000;
        end else begin
            // Memory read is registered: data for this cycle's address of an
            // active read shows up next cycle. Writes produce no read data.
            rd_valid <= grant & req & ~{2'b00, r0_write};
            case (state)
                IDLE: begin
                    if (|req) begin
                        grant      <= 3'b001 << winner;
                        last_owner <= winner;
                        state      <= OWN;
                    end
                end
                OWN: begin
                    // Others' requests are ignored while the owner holds.
                    if (!owner_holds) begin
                        grant <= 3'b000;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        grid_x     = '0;
        grid_y     = '0;
        grid_in    = '0;
        grid_write = 1'b0;
        if (grant[0]) begin
            grid_x     = r0_x;
            grid_y     = r0_y;
            grid_in    = r0_in;
            // Suppress the write once reset is sampled, even though the
            // registered grant only clears at the coming edge.
            grid_write = r0_write & req[0] & ~reset;
        end else if (grant[1]) begin
            grid_x = r1_x;
            grid_y = r1_y;
        end else if (grant[2]) begin
            grid_x = r2_x;
            grid_y = r2_y;
        end
    end

    assign busy = |grant;

endmodule

// File: tb/tb_grid_arbiter.sv
module tb_grid_arbiter;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] req = '0;
    logic [5:0] r0_x = '0, r1_x = '0, r2_x = '0;
    logic [4:0] r0_y = '0, r1_y = '0, r2_y = '0;
    logic       r0_write = 1'b0;
    logic [2:0] r0_in = '0;
    logic [2:0] grant, rd_valid, grid_in;
    logic [5:0] grid_x;
    logic [4:0] grid_y;
    logic       grid_write, busy;

    grid_arbiter dut (
        .clock(clock), .reset(reset), .req(req),
        .r0_x(r0_x), .r0_y(r0_y), .r0_write(r0_write), .r0_in(r0_in),
        .r1_x(r1_x), .r1_y(r1_y), .r2_x(r2_x), .r2_y(r2_y),
        .grant(grant), .rd_valid(rd_valid),
        .grid_x(grid_x), .grid_y(grid_y), .grid_write(grid_write),
        .grid_in(grid_in), .busy(busy)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic       rs;
        logic [2:0] rq;
        logic       w;
        logic [5:0] x0;
        logic [4:0] y0;
        logic [2:0] d0;
        logic [5:0] x1;
        logic [4:0] y1;
        logic [5:0] x2;
        logic [4:0] y2;
    } stim_t;

    typedef struct packed {
        logic [2:0] grant;
        logic [2:0] rdv;
        logic       busy;
        logic [5:0] gx;
        logic [4:0] gy;
        logic       gw;
        logic [2:0] gin;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   passes = 0;

    // Reference model: owner index (-1 = nobody), previous owner, read-valid.
    int         m_owner = -1;
    int         m_last = 2;
    logic [2:0] m_rdv = '0;

    // Applied at each rising edge, using the inputs held across that edge.
    task automatic model_edge();
        if (reset) begin
            m_owner = -1;
            m_last  = 2;
            m_rdv   = '0;
        end else begin
            m_rdv = '0;
            if (m_owner >= 0 && req[m_owner] && !(m_owner == 0 && r0_write))
                m_rdv[m_owner] = 1'b1;
            if (m_owner >= 0) begin
                if (!req[m_owner]) m_owner = -1;
            end else if (req != 3'b000) begin
                for (int k = 1; k <= 3; k++) begin
                    int c;
                    c = (m_last + k) % 3;
                    if (req[c]) begin
                        m_owner = c;
                        m_last  = c;
                        break;
                    end
                end
            end
        end
    endtask

    function automatic exp_t expect_now();
        exp_t e;
        e = '0;
        e.rdv = m_rdv;
        if (m_owner >= 0) e.grant[m_owner] = 1'b1;
        e.busy = (m_owner >= 0);
        case (m_owner)
            0: begin
                e.gx  = r0_x;
                e.gy  = r0_y;
                e.gin = r0_in;
                e.gw  = req[0] && r0_write && !reset;
            end
            1: begin e.gx = r1_x; e.gy = r1_y; end
            2: begin e.gx = r2_x; e.gy = r2_y; end
            default: ;
        endcase
        return e;
    endfunction

    task automatic cyc(input stim_t s);
        @(posedge clock);
        model_edge();
        #1;
        reset = s.rs; req = s.rq; r0_write = s.w;
        r0_x = s.x0; r0_y = s.y0; r0_in = s.d0;
        r1_x = s.x1; r1_y = s.y1; r2_x = s.x2; r2_y = s.y2;
        #0;
        sb.push_back(expect_now());
    endtask

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) $display("FAIL %s t=%0t actual=%0h expected=%0h", n, $time, a, e);
        else passes++;
    endtask

    always @(negedge clock) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("grant",      32'(grant),      32'(e.grant));
            chk("rd_valid",   32'(rd_valid),   32'(e.rdv));
            chk("busy",       32'(busy),       32'(e.busy));
            chk("grid_x",     32'(grid_x),     32'(e.gx));
            chk("grid_y",     32'(grid_y),     32'(e.gy));
            chk("grid_write", 32'(grid_write), 32'(e.gw));
            chk("grid_in",    32'(grid_in),    32'(e.gin));
        end
    end

    initial begin
        stim_t s;
        s = '0;
        s.rs = 1'b1;
        repeat (2) cyc(s);
        s.rs = 1'b0;

        // All three request: 0, dead cycle, 1, dead cycle, 2.
        s.rq = 3'b111; repeat (3) cyc(s);
        s.rq = 3'b110; repeat (3) cyc(s);
        s.rq = 3'b100; repeat (3) cyc(s);
        s.rq = 3'b000; repeat (2) cyc(s);

        // Owner 0 writes.
        s.rq = 3'b001; s.w = 1'b1; s.x0 = 6'd5; s.y0 = 5'd3; s.d0 = 3'd6;
        repeat (3) cyc(s);
        s.w = 1'b0; s.rq = 3'b000; repeat (2) cyc(s);

        // Requester 1 reads for several granted cycles.
        s.rq = 3'b010; s.x1 = 6'd10; s.y1 = 5'd7; repeat (5) cyc(s);
        s.rq = 3'b000; repeat (2) cyc(s);

        // No preemption, no write from a non-owner.
        s.rq = 3'b010; repeat (2) cyc(s);
        s.rq = 3'b111; s.w = 1'b1; repeat (3) cyc(s);
        s.rq = 3'b000; s.w = 1'b0; repeat (2) cyc(s);

        // Reset during ownership by 2, then 0 wins first.
        s.rq = 3'b100; s.x2 = 6'd33; s.y2 = 5'd21; repeat (3) cyc(s);
        s.rs = 1'b1; cyc(s);
        s.rs = 1'b0; s.rq = 3'b101; repeat (3) cyc(s);

        // Reset while owner 0 writes: write suppressed in the reset cycle.
        s.rq = 3'b001; s.w = 1'b1; repeat (2) cyc(s);
        s.rs = 1'b1; cyc(s);
        s.rs = 1'b0; s.rq = 3'b000; s.w = 1'b0; cyc(s);

        // Idle with junk addresses.
        repeat (10) begin
            s.x0 = 6'($urandom); s.x1 = 6'($urandom); s.x2 = 6'($urandom);
            s.y0 = 5'($urandom); s.y1 = 5'($urandom); s.y2 = 5'($urandom);
            cyc(s);
        end

        // Random traffic: sticky requests, occasional reset.
        repeat (600) begin
            for (int b = 0; b < 3; b++)
                if ($urandom_range(3) == 0) s.rq[b] = ~s.rq[b];
            s.rs = ($urandom_range(99) == 0);
            s.w  = 1'($urandom);
            s.x0 = 6'($urandom); s.x1 = 6'($urandom); s.x2 = 6'($urandom);
            s.y0 = 5'($urandom); s.y1 = 5'($urandom); s.y2 = 5'($urandom);
            s.d0 = 3'($urandom);
            cyc(s);
        end

        repeat (2) @(negedge clock);
        #1;
        checks++;
        if (sb.size() != 0) $display("FAIL drain actual=%0d expected=0", sb.size());
        else passes++;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
